// File: rtl/result_reader_pkg.sv
// rtl/result_reader_pkg.sv - shared constants for the result FIFO drain path
//
// Purpose: FSM state encodings and word/byte geometry shared by
//          result_reader and its byte_shifter.
// Ports:   none (package).
package result_reader_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  // Native width of the engine's result words and their packing into bytes
  localparam int RESULT_W       = 21;
  localparam int BYTES_PER_WORD = 3;
  localparam int PAD_W          = 24 - RESULT_W;

endpackage

// File: rtl/result_reader_byte_shifter.sv
// rtl/result_reader_byte_shifter.sv - 24-bit load/shift register that presents one byte at a time
//
// Purpose: holds the word being transmitted, always presenting its top byte;
//          each shift moves the next byte up and advances the byte index.
// Ports:   clk, rst (async active-low), load/din (capture a new word, index=0),
//          shift (advance one byte), byte_out (current byte), last (index is
//          at the final byte of the word).
module byte_shifter
  import result_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift,
  input  logic [23:0] din,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [23:0] sr;
  logic [1:0]  idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= din;
      idx <= '0;
    end else if (shift) begin
      sr  <= {sr[15:0], 8'h00};
      idx <= idx + 2'd1;
    end
  end

  assign byte_out = sr[23:16];
  assign last     = (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/result_reader.sv
// rtl/result_reader.sv - drains the result FIFO and streams each word as three bytes
//
// Purpose: consumer of a non-show-ahead FIFO (q valid the cycle after rdreq).
//          Each word is read, zero-extended to 24 bits and sent MSB first over
//          a valid/ready byte stream; word_count tallies fully delivered words.
// Ports:   clk, rst (async active-low), enable (allow starting a new word),
//          empty/q/rdreq (FIFO read side), tx_data/tx_valid/tx_ready (byte
//          stream), busy (not idle), word_count (words delivered, wraps).
module result_reader
  import result_reader_pkg::*;
#(
  parameter int DATA_W = RESULT_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] q,
  output logic              rdreq,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  logic [1:0]  state;
  logic        hs;
  logic        last;
  logic [23:0] load_word;

  assign hs        = tx_valid && tx_ready;
  assign load_word = 24'(q);

  // All outputs decode from registered state, so tx_ready never reaches
  // tx_valid combinationally and everything reads 0 while in reset.
  assign rdreq    = (state == ST_REQ);
  assign tx_valid = (state == ST_SEND);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enable && !empty) state <= ST_REQ;
        ST_REQ:  state <= ST_CAPT;
        // q is valid this cycle; byte_shifter captures it on the closing edge
        ST_CAPT: state <= ST_SEND;
        ST_SEND: begin
          // enable is ignored here: a started word is always finished
          if (hs && last) begin
            word_count <= word_count + 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  byte_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_CAPT),
    .shift    (hs),
    .din      (load_word),
    .byte_out (tx_data),
    .last     (last)
  );

endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - directed self-checking bench for result_reader
module tb_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        empty;
  logic [20:0] q = '0;
  logic        rdreq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  word_count;

  int checks = 0;
  int errors = 0;

  logic [20:0] fifo[$];
  logic [7:0]  rx[$];
  logic [7:0]  expq[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          rdreq_cnt = 0;
  int          rdreq_cyc = 0;

  always #5 clk = ~clk;

  result_reader #(.DATA_W(21), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .empty      (empty),
    .q          (q),
    .rdreq      (rdreq),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .word_count (word_count)
  );

  // Legacy-mode FIFO model: q updates on the edge that samples rdreq
  assign empty = (fifo.size() == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdreq && fifo.size() > 0) begin
      q <= fifo[0];
      fifo.delete(0);
    end
  end

  // Stream monitor, sampled mid-cycle ahead of the edge that completes it
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      rx.push_back(tx_data);
      hs_cyc.push_back(cyc);
    end
    if (rdreq) begin
      rdreq_cnt <= rdreq_cnt + 1;
      rdreq_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [20:0] w);
    fifo.push_back(w);
    expq.push_back({3'b000, w[20:16]});
    expq.push_back(w[15:8]);
    expq.push_back(w[7:0]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdreq"}, 32'(rdreq), 0);
    check({tag, "_valid"}, 32'(tx_valid), 0);
    check({tag, "_data"}, 32'(tx_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_count"}, 32'(word_count), 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(fifo.size() == 0 && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= budget), 0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= budget), 0);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_nbytes"}, 32'(rx.size()), 32'(expq.size()));
    n = (rx.size() < expq.size()) ? rx.size() : expq.size();
    for (int i = 0; i < n; i++) check(tag, 32'(rx[i]), 32'(expq[i]));
    rx.delete();
    expq.delete();
    hs_cyc.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    int n;
    logic [7:0] bp_bytes [3];

    rst = 1'b0;
    enable = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    check_zero("reset");
    tick(2);
    rst = 1'b1;
    tick(1);

    // Single word, ready held high
    base = rdreq_cnt;
    tx_ready = 1'b1;
    enable = 1'b1;
    push(21'h1ABCDE);
    wait_drain("single", 50);
    check("single_rdreq", 32'(rdreq_cnt - base), 1);
    check("single_b0", 32'(rx.size() > 0 ? rx[0] : 8'hxx), 32'h1A);
    check("single_b1", 32'(rx.size() > 1 ? rx[1] : 8'hxx), 32'hBC);
    check("single_b2", 32'(rx.size() > 2 ? rx[2] : 8'hxx), 32'hDE);
    if (hs_cyc.size() == 3) begin
      check("single_lat", 32'(hs_cyc[0] - rdreq_cyc), 2);
      check("single_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 1);
      check("single_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 1);
    end
    compare_stream("single");
    check("single_count", 32'(word_count), 1);
    check("single_busy", 32'(busy), 0);

    // Backpressure: four stalled cycles on every byte
    base = rdreq_cnt;
    tx_ready = 1'b0;
    push(21'h0F00F0);
    bp_bytes[0] = 8'h0F;
    bp_bytes[1] = 8'h00;
    bp_bytes[2] = 8'hF0;
    wait_valid("bp", 20);
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 4; s++) begin
        check("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, bp_bytes[b]});
        @(negedge clk);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      @(negedge clk);
    end
    wait_drain("bp", 20);
    check("bp_rdreq", 32'(rdreq_cnt - base), 1);
    compare_stream("bp");
    check("bp_count", 32'(word_count), 2);

    // Empty gating
    tx_ready = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdreq || tx_valid) bad++;
    end
    check("empty_gate", 32'(bad), 0);
    tick(1);
    push(21'h000001);
    wait_drain("empty", 50);
    compare_stream("empty");
    check("empty_count", 32'(word_count), 3);

    // Enable dropped after byte0 handshake with two words queued
    enable = 1'b0;
    tick(1);
    base = rdreq_cnt;
    push(21'h123456);
    fifo.push_back(21'h0ABCDE);
    enable = 1'b1;
    n = 0;
    while (rx.size() < 1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("endrop_timeout", 32'(n >= 30), 0);
    @(posedge clk); #1;
    enable = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    tick(10);
    check("endrop_rdreq", 32'(rdreq_cnt - base), 1);
    check("endrop_left", 32'(fifo.size()), 1);
    check("endrop_busy", 32'(busy), 0);
    compare_stream("endrop");
    check("endrop_count", 32'(word_count), 4);
    fifo.delete();

    // Reset asserted while byte1 is on the wire
    tx_ready = 1'b0;
    enable = 1'b1;
    push(21'h0C0DE5);
    wait_valid("rstmid", 20);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("rstmid_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h0D});
    #2;
    rst = 1'b0;
    #1;
    check_zero("rstmid");
    check("rstmid_nbytes", 32'(rx.size()), 1);
    rx.delete();
    expq.delete();
    hs_cyc.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    base = rdreq_cnt;
    tx_ready = 1'b1;
    push(21'h155AA3);
    wait_drain("rstmid_after", 50);
    check("rstmid_rdreq", 32'(rdreq_cnt - base), 1);
    check("rstmid_x0", 32'(rx.size() > 0 ? rx[0] : 8'hxx), 32'h15);
    check("rstmid_x1", 32'(rx.size() > 1 ? rx[1] : 8'hxx), 32'h5A);
    check("rstmid_x2", 32'(rx.size() > 2 ? rx[2] : 8'hxx), 32'hA3);
    compare_stream("rstmid_after");
    check("rstmid_count", 32'(word_count), 1);

    // Counter wrap: 257 words from a fresh reset
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("wrap_start", 32'(word_count), 0);
    base = rdreq_cnt;
    for (int i = 0; i < 257; i++) push(21'(i * 7919 + 3));
    wait_drain("wrap", 2500);
    check("wrap_rdreq", 32'(rdreq_cnt - base), 257);
    compare_stream("wrap");
    check("wrap_count", 32'(word_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_reader.md
# result_reader

Drains the 21-bit result FIFO that sits behind the compute engine (FIFO in legacy/non-show-ahead mode: `q` valid the cycle after `rdreq`) and forwards each result as three bytes over a valid/ready byte stream. It is the consumer end of the FIFO's `rdreq`/`empty`/`q` interface, placed between the engine wrapper and the byte-wide host link. It also keeps a running count of words delivered.

## Interface
Parameters:
- `DATA_W`, 21: FIFO word width; bits above 24 are not supported.
- `CNT_W`, 8: width of `word_count`.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `enable` input 1: when high, the block may start draining a new word.
- `empty` input 1: FIFO empty flag.
- `q` input DATA_W: FIFO read data, valid the cycle after `rdreq`.
- `rdreq` output 1: FIFO read request, one-cycle pulse per word.
- `tx_data` output 8: outgoing byte.
- `tx_valid` output 1: `tx_data` holds a valid byte.
- `tx_ready` input 1: sink accepts the byte when `tx_valid && tx_ready` on a clock edge.
- `busy` output 1: high in any state except IDLE.
- `word_count` output CNT_W: number of words whose last byte has been accepted.

## Operation
- Reset (`rst` low, asynchronous): state IDLE, `rdreq`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `word_count`=0, shift register and byte index cleared.
- FSM states: IDLE, REQ, CAPT, SEND.
  - IDLE: if `enable && !empty`, go to REQ; otherwise stay.
  - REQ: `rdreq`=1 for exactly this cycle; go to CAPT.
  - CAPT: latch `q` zero-extended to 24 bits into the shift register; byte index=0; go to SEND.
  - SEND: `tx_valid`=1, `tx_data` = shift register bits [23:16]. On handshake: shift left by 8; index+1. On the handshake for index 2, increment `word_count` and go to IDLE.
- Byte order is MSB first: byte0 = {3'b000, q[20:16]}, byte1 = q[15:8], byte2 = q[7:0].
- `rdreq` is asserted only from REQ, and only if `empty` was low when entering REQ. It is never asserted while in CAPT or SEND.
- Deasserting `enable` mid-word does not abort the word. All three bytes are delivered before the block returns to IDLE and idles there.
- `word_count` wraps from 2^CNT_W−1 to 0.
- Reset asserted mid-word: the word in flight is discarded. No partial-word recovery.

## Timing
- From IDLE with `enable`=1 and `empty`=0 at edge t:
  - REQ during cycle t+1 (`rdreq` high).
  - CAPT during cycle t+2 (`q` sampled at its closing edge).
  - First `tx_valid` during cycle t+3.
- With `tx_ready` held high, each word occupies 6 cycles: IDLE, REQ, CAPT, and 3×SEND. The next word's REQ starts no earlier than 2 cycles after the last byte handshake.
- While `tx_valid && !tx_ready`, `tx_data` and `tx_valid` hold stable.
- `tx_valid` never drops without a handshake, except on reset.
- `tx_ready` may be high before `tx_valid`. The protocol has no combinational path from `tx_ready` to `tx_valid`.
- `word_count` updates on the same edge as the third byte's handshake.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, REQ, CAPT, SEND);
  - `BYTES_PER_WORD` = 3;
  - `PAD_W` = 24 − DATA_W.
- One sub-module is natural: `byte_shifter`, a 24-bit load/shift register with a 2-bit byte index and a `last` flag. The FSM stays in `result_reader`.

## Test plan
- Single word: preload FIFO with 21'h1ABCDE, `enable`=1, `tx_ready`=1 → `rdreq` pulses once; bytes 8'h1A, 8'hBC, 8'hDE appear on consecutive cycles; `word_count`=1; `busy` returns to 0.
- Backpressure: word 21'h0F00F0 with `tx_ready` low for 4 cycles on each byte → each byte (8'h0F, 8'h00, 8'hF0) is held stable while stalled; exactly 3 handshakes occur.
- Empty gating: `enable`=1, `empty`=1 for 20 cycles → `rdreq` is never asserted and `tx_valid` stays 0. Then push 21'h000001 → bytes 00, 00, 01.
- Enable drop mid-word: lower `enable` after byte0's handshake with 2 words queued → the remaining 2 bytes are sent, no further `rdreq`, `word_count`=1.
- Reset mid-word: assert `rst` low during byte1 → all outputs go to 0 immediately. After release with 1 word queued, a full 3-byte sequence follows and `word_count`=1.
- Counter wrap: stream 257 words → `word_count`=1.
